// File: rtl/parity_push_stage.sv
// Parity-encoding push stage: appends a parity bit to each producer word and
// feeds the FIFO through a 2-entry skid buffer (OUT + SKID) with debug counters.
module parity_push_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_corrupt_i,
  input  logic                  in_valid_i,
  output logic                  in_grant_o,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [15:0]           word_count_o,
  output logic [15:0]           corrupt_count_o
);

  localparam int W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   enc_data, out_data, skid_data;
  logic           parity, out_corrupt, skid_corrupt;
  logic           accept, deliver;
  logic           load_out_in, load_out_skid, load_skid;
  logic [15:0]    word_cnt, corrupt_cnt;

  // Encode before storage so both registers hold ready-to-push words.
  always_comb begin
    parity = (^in_data_i) ^ (EVEN_ODD != 0) ^ in_corrupt_i;
    if (PARITY_BIT != 0) enc_data = {parity, in_data_i};
    else                 enc_data = {in_data_i, parity};
  end

  assign accept       = in_valid_i & in_grant_o;
  assign deliver      = push_valid_o & push_grant_i;
  assign push_valid_o = (state != EMPTY);
  assign push_data_o  = out_data;
  assign word_count_o    = word_cnt;
  assign corrupt_count_o = corrupt_cnt;

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt   = ONE;
        load_out_in = 1'b1;
      end
      ONE: begin
        if (accept && !deliver) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept && deliver) begin
          load_out_in = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (deliver) begin
        state_nxt     = ONE;
        load_out_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      in_grant_o   <= 1'b0;
      out_data     <= '0;
      out_corrupt  <= 1'b0;
      skid_data    <= '0;
      skid_corrupt <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_grant_o <= (state_nxt != FULL);
      if (load_out_in) begin
        out_data    <= enc_data;
        out_corrupt <= in_corrupt_i;
      end else if (load_out_skid) begin
        out_data    <= skid_data;
        out_corrupt <= skid_corrupt;
      end
      if (load_skid) begin
        skid_data    <= enc_data;
        skid_corrupt <= in_corrupt_i;
      end
    end
  end

  // Word count wraps; corrupt count saturates so a long soak stays readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= '0;
      corrupt_cnt <= '0;
    end else if (deliver) begin
      word_cnt <= word_cnt + 16'd1;
      if (out_corrupt && corrupt_cnt != 16'hFFFF) corrupt_cnt <= corrupt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_parity_push_stage.sv
// Randomized self-checking bench for parity_push_stage against a queue-based
// reference model of the skid-buffered push path.
module tb_parity_push_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data_i;
  logic        in_corrupt_i, in_valid_i, push_grant_i;
  logic        in_grant_o, push_valid_o;
  logic [32:0] push_data_o;
  logic [15:0] word_count_o, corrupt_count_o;

  logic        o_grant, o_valid, m_grant, m_valid;
  logic [32:0] o_data, m_data;
  logic [15:0] o_wc, o_cc, m_wc, m_cc;

  int vecs = 0;
  int errs = 0;

  // Reference model: queue of {corrupt, encoded word} held in the stage.
  logic [33:0] sb[$];
  int          wc_m;
  int          cc_m;
  logic        grant_m;

  always #5 clk = ~clk;

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(0)) dut (
    .clk(clk), .rst(rst), .in_data_i(in_data_i), .in_corrupt_i(in_corrupt_i),
    .in_valid_i(in_valid_i), .in_grant_o(in_grant_o), .push_data_o(push_data_o),
    .push_valid_o(push_valid_o), .push_grant_i(push_grant_i),
    .word_count_o(word_count_o), .corrupt_count_o(corrupt_count_o));

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(1), .PARITY_BIT(0)) dut_odd (
    .clk(clk), .rst(rst), .in_data_i(in_data_i), .in_corrupt_i(in_corrupt_i),
    .in_valid_i(in_valid_i), .in_grant_o(o_grant), .push_data_o(o_data),
    .push_valid_o(o_valid), .push_grant_i(push_grant_i),
    .word_count_o(o_wc), .corrupt_count_o(o_cc));

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(1)) dut_msb (
    .clk(clk), .rst(rst), .in_data_i(in_data_i), .in_corrupt_i(in_corrupt_i),
    .in_valid_i(in_valid_i), .in_grant_o(m_grant), .push_data_o(m_data),
    .push_valid_o(m_valid), .push_grant_i(push_grant_i),
    .word_count_o(m_wc), .corrupt_count_o(m_cc));

  function automatic logic [32:0] enc(input logic [31:0] d, input logic c,
                                      input int eo, input int pb);
    logic p;
    p = (($countones(d) % 2) != 0) ^ (eo != 0) ^ c;
    return (pb != 0) ? {p, d} : {d, p};
  endfunction

  // Advance one cycle: sample handshakes, clock edge, update model.
  task automatic step();
    logic acc, del;
    acc = in_valid_i && in_grant_o;
    del = push_valid_o && push_grant_i;
    @(posedge clk);
    if (del && sb.size() > 0) begin
      if (sb[0][33] && cc_m < 16'hFFFF) cc_m++;
      void'(sb.pop_front());
      wc_m = (wc_m + 1) % 65536;
    end
    if (acc) sb.push_back({in_corrupt_i, enc(in_data_i, in_corrupt_i, 0, 0)});
    grant_m = (sb.size() < 2);
    @(negedge clk);
  endtask

  task automatic model_clear();
    sb.delete();
    wc_m = 0; cc_m = 0; grant_m = 1'b0;
  endtask

  task automatic drain();
    in_valid_i = 1'b0; push_grant_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 0; in_data_i = 0; in_corrupt_i = 0; push_grant_i = 0;
    model_clear();
    repeat (2) @(negedge clk);
    vecs++; if (push_valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", push_valid_o); end
    vecs++; if (push_data_o !== 33'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", push_data_o); end
    vecs++; if (in_grant_o !== 1'b0) begin errs++; $display("FAIL reset_grant got=%b exp=0", in_grant_o); end
    vecs++; if (word_count_o !== 16'h0 || corrupt_count_o !== 16'h0) begin
      errs++; $display("FAIL reset_counts got=%h/%h exp=0/0", word_count_o, corrupt_count_o); end
    rst = 1'b0;
    step();
    vecs++; if (in_grant_o !== 1'b1) begin errs++; $display("FAIL release_grant got=%b exp=1", in_grant_o); end
  endtask

  task automatic test_encoding();
    push_grant_i = 1'b1; in_valid_i = 1'b1; in_corrupt_i = 1'b0; in_data_i = 32'h3;
    step();
    vecs++; if (push_data_o !== 33'h0_0000_0006) begin errs++; $display("FAIL enc_even3 got=%h exp=006", push_data_o); end
    vecs++; if (o_data !== 33'h0_0000_0007) begin errs++; $display("FAIL enc_odd3 got=%h exp=007", o_data); end
    vecs++; if (m_data !== 33'h0_0000_0003) begin errs++; $display("FAIL enc_msb3 got=%h exp=0_00000003", m_data); end
    in_data_i = 32'h1;
    step();
    vecs++; if (push_data_o !== 33'h0_0000_0003) begin errs++; $display("FAIL enc_even1 got=%h exp=003", push_data_o); end
    vecs++; if (o_data !== 33'h0_0000_0002) begin errs++; $display("FAIL enc_odd1 got=%h exp=002", o_data); end
    vecs++; if (m_data !== 33'h1_0000_0001) begin errs++; $display("FAIL enc_msb1 got=%h exp=1_00000001", m_data); end
    drain();
    vecs++; if (o_valid !== 1'b0 || m_valid !== 1'b0 || o_grant !== 1'b1 || m_grant !== 1'b1) begin
      errs++; $display("FAIL enc_variant_hs got=%b%b%b%b exp=0011", o_valid, m_valid, o_grant, m_grant); end
    vecs++; if (o_wc !== 16'(wc_m) || m_wc !== 16'(wc_m) || o_cc !== 16'(cc_m) || m_cc !== 16'(cc_m)) begin
      errs++; $display("FAIL enc_variant_cnt got=%h/%h/%h/%h exp=%h/%h", o_wc, m_wc, o_cc, m_cc, wc_m, cc_m); end
  endtask

  task automatic test_streaming();
    int wc0;
    wc0 = wc_m;
    push_grant_i = 1'b1; in_valid_i = 1'b1; in_corrupt_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_data_i = 32'(k);
      step();
      vecs++; if (push_valid_o !== 1'b1 || push_data_o !== enc(32'(k), 1'b0, 0, 0) || in_grant_o !== 1'b1) begin
        errs++; $display("FAIL stream_word%0d got=%b/%h/%b exp=1/%h/1", k, push_valid_o, push_data_o,
                         in_grant_o, enc(32'(k), 1'b0, 0, 0)); end
    end
    in_valid_i = 1'b0;
    step();
    vecs++; if (word_count_o !== 16'(wc0 + 10)) begin
      errs++; $display("FAIL stream_count got=%0d exp=%0d", word_count_o, wc0 + 10); end
  endtask

  task automatic test_backpressure();
    logic [32:0] held[$];
    int          n;
    push_grant_i = 1'b0; in_valid_i = 1'b1; in_corrupt_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data_i = $urandom;
      if (in_grant_o) held.push_back(enc(in_data_i, 1'b0, 0, 0));
      step();
      if (held.size() > 0) begin
        vecs++; if (push_data_o !== held[0]) begin
          errs++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, push_data_o, held[0]); end
      end
    end
    vecs++; if (held.size() != 2 || in_grant_o !== 1'b0) begin
      errs++; $display("FAIL bp_full held=%0d grant=%b exp=2/0", held.size(), in_grant_o); end
    in_valid_i = 1'b0; push_grant_i = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (push_valid_o) begin
        vecs++; if (held.size() == 0 || push_data_o !== held[0]) begin
          errs++; $display("FAIL bp_order got=%h exp=%h", push_data_o, (held.size() > 0) ? held[0] : 33'h0); end
        if (held.size() > 0) void'(held.pop_front());
        n++;
      end
      step();
    end
    vecs++; if (n != 2 || push_valid_o !== 1'b0) begin
      errs++; $display("FAIL bp_release delivered=%0d valid=%b exp=2/0", n, push_valid_o); end
  endtask

  task automatic test_corruption();
    int cc0;
    cc0 = cc_m;
    push_grant_i = 1'b1; in_valid_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data_i = 32'(k + 100);
      in_corrupt_i = (k == 3 || k == 7);
      step();
      vecs++; if (push_data_o !== enc(32'(k + 100), (k == 3 || k == 7), 0, 0)) begin
        errs++; $display("FAIL corrupt_word%0d got=%h exp=%h", k, push_data_o,
                         enc(32'(k + 100), (k == 3 || k == 7), 0, 0)); end
    end
    in_corrupt_i = 1'b0;
    drain();
    vecs++; if (corrupt_count_o !== 16'(cc0 + 2)) begin
      errs++; $display("FAIL corrupt_count got=%0d exp=%0d", corrupt_count_o, cc0 + 2); end
  endtask

  task automatic test_saturation();
    force dut.corrupt_cnt = 16'hFFFD;
    #1 release dut.corrupt_cnt;
    cc_m = 16'hFFFD;
    push_grant_i = 1'b1; in_valid_i = 1'b1; in_corrupt_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin in_valid_i = 1'b0; in_corrupt_i = 1'b0; end
      in_data_i = $urandom;
      step();
      vecs++; if (corrupt_count_o !== 16'(cc_m)) begin
        errs++; $display("FAIL sat_step%0d got=%h exp=%h", c, corrupt_count_o, cc_m); end
    end
    vecs++; if (corrupt_count_o !== 16'hFFFF) begin
      errs++; $display("FAIL sat_hold got=%h exp=ffff", corrupt_count_o); end
  endtask

  task automatic test_reset_midop();
    push_grant_i = 1'b0; in_valid_i = 1'b1; in_corrupt_i = 1'b0;
    repeat (3) begin in_data_i = $urandom; step(); end
    vecs++; if (in_grant_o !== 1'b0 || push_valid_o !== 1'b1) begin
      errs++; $display("FAIL midrst_full grant=%b valid=%b exp=0/1", in_grant_o, push_valid_o); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (push_valid_o !== 1'b0 || word_count_o !== 16'h0 || corrupt_count_o !== 16'h0 || in_grant_o !== 1'b0) begin
      errs++; $display("FAIL midrst_async valid=%b wc=%h cc=%h grant=%b exp=0/0/0/0",
                       push_valid_o, word_count_o, corrupt_count_o, in_grant_o); end
    model_clear();
    @(negedge clk);
    rst = 1'b0; in_valid_i = 1'b0;
    vecs++; if (in_grant_o !== 1'b0) begin errs++; $display("FAIL midrst_pre got=%b exp=0", in_grant_o); end
    step();
    vecs++; if (in_grant_o !== 1'b1 || push_valid_o !== 1'b0) begin
      errs++; $display("FAIL midrst_release grant=%b valid=%b exp=1/0", in_grant_o, push_valid_o); end
  endtask

  task automatic test_random();
    int acc_n, del_n;
    acc_n = 0; del_n = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid_i   = ($urandom % 2) != 0;
      push_grant_i = ($urandom % 2) != 0;
      in_data_i    = $urandom;
      in_corrupt_i = ($urandom % 8) == 0;
      if (in_valid_i && in_grant_o) acc_n++;
      if (push_valid_o && push_grant_i) del_n++;
      step();
      vecs++; if (push_valid_o !== (sb.size() > 0) || in_grant_o !== grant_m) begin
        errs++; $display("FAIL rand_hs cyc=%0d valid=%b grant=%b exp=%b/%b", c, push_valid_o, in_grant_o,
                         sb.size() > 0, grant_m); end
      if (sb.size() > 0) begin
        vecs++; if (push_data_o !== sb[0][32:0]) begin
          errs++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, push_data_o, sb[0][32:0]); end
      end
      vecs++; if (word_count_o !== 16'(wc_m) || corrupt_count_o !== 16'(cc_m)) begin
        errs++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, word_count_o, corrupt_count_o,
                         wc_m, cc_m); end
    end
    in_valid_i = 1'b0; push_grant_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (push_valid_o) del_n++;
      step();
    end
    vecs++; if (acc_n != del_n || push_valid_o !== 1'b0) begin
      errs++; $display("FAIL rand_drain accepted=%0d delivered=%0d valid=%b", acc_n, del_n, push_valid_o); end
  endtask

  initial begin
    test_reset();
    test_encoding();
    test_streaming();
    test_backpressure();
    test_corruption();
    test_saturation();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
